// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants and helpers for the stream multiplexer.
//   MODE_RR / MODE_FIXED / MODE_SEL - arbitration mode encodings
//   sw_width(n)                     - width of a channel index for n channels
package stream_mux_pkg;

    localparam int unsigned MODE_RR    = 0;
    localparam int unsigned MODE_FIXED = 1;
    localparam int unsigned MODE_SEL   = 2;

    function automatic int unsigned sw_width(input int unsigned n);
        return (n < 2) ? 1 : $unsigned($clog2(n));
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: round-robin arbiter over N requesters.
//   clk, rst   - clock, synchronous active-high reset
//   req        - request vector
//   advance    - grant was consumed this cycle; remember it as the last winner
//   grant      - one-hot grant (zero when no request)
//   grant_idx  - index of the granted requester
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned SW = sw_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx
);

    logic [SW-1:0] ptr_q, ptr_d;
    logic          found;

    // Two passes: channels above ptr first, then wrap to 0..ptr. Iterating over
    // real channel indices keeps the wrap at N rather than at 2^SW.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (SW'(i) > ptr_q)) begin
                grant[i]  = 1'b1;
                grant_idx = SW'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (SW'(i) <= ptr_q)) begin
                grant[i]  = 1'b1;
                grant_idx = SW'(i);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = grant_idx;
        end
    end

    // Reset to N-1 so the first search begins at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= SW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-input registered stream multiplexer with valid/ready handshakes.
//   clk, rst                     - clock, synchronous active-high reset
//   in_data / in_valid / in_ready - N input streams, channel i at [i*WIDTH +: WIDTH]
//   sel                          - channel select (MODE_SEL only)
//   out_data / out_valid / out_ready - single registered output stream
//   out_src                      - index of the channel that supplied out_data
// MODE: 0 round-robin, 1 fixed priority (lowest index), 2 external select.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = MODE_RR,
    localparam int unsigned SW   = sw_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SW-1:0]      out_src
);

    logic [N-1:0]     rr_grant, fx_grant, sl_grant, grant;
    logic [SW-1:0]    rr_idx, fx_idx, sl_idx, grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             load, in_xfer;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (in_xfer && (MODE == MODE_RR)),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Fixed priority: scan downward so the lowest valid index is the last write.
    always_comb begin
        fx_grant = '0;
        fx_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                fx_grant    = '0;
                fx_grant[i] = 1'b1;
                fx_idx      = SW'(i);
            end
        end
    end

    // External select: an out-of-range sel matches no channel and grants nothing.
    always_comb begin
        sl_grant = '0;
        sl_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if ((sel == SW'(i)) && in_valid[i]) begin
                sl_grant[i] = 1'b1;
                sl_idx      = SW'(i);
            end
        end
    end

    always_comb begin
        case (MODE)
            MODE_RR: begin
                grant     = rr_grant;
                grant_idx = rr_idx;
            end
            MODE_FIXED: begin
                grant     = fx_grant;
                grant_idx = fx_idx;
            end
            default: begin
                grant     = sl_grant;
                grant_idx = sl_idx;
            end
        endcase
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load     = !out_valid_q || out_ready;
    assign in_ready = (load && !rst) ? grant : '0;
    assign in_xfer  = |in_ready;

    // A simultaneous input and output transfer simply reloads: no bubble.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (in_xfer) begin
            out_data_d  = grant_data;
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed bench for stream_mux. Four instances share clock and
// reset: round-robin, fixed priority and external select at N=4, and
// round-robin at N=3 for the non-power-of-two wrap.
module tb_stream_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    logic [3:0]  in_valid = 4'b1111;
    logic [1:0]  sel = 2'd0;
    logic        out_ready = 1'b1;
    logic [23:0] in_data3 = {8'hC2, 8'hC1, 8'hC0};
    logic [2:0]  in_valid3 = 3'b000;
    logic [1:0]  sel3 = 2'd0;

    logic [3:0] rr_in_ready, fx_in_ready, sl_in_ready;
    logic [7:0] rr_out_data, fx_out_data, sl_out_data;
    logic       rr_out_valid, fx_out_valid, sl_out_valid;
    logic [1:0] rr_out_src, fx_out_src, sl_out_src;
    logic [2:0] in_ready3;
    logic [7:0] out_data3;
    logic       out_valid3;
    logic [1:0] out_src3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    stream_mux #(.WIDTH(8), .N(4), .MODE(0)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rr_in_ready),
        .sel(sel), .out_data(rr_out_data), .out_valid(rr_out_valid), .out_ready(out_ready),
        .out_src(rr_out_src)
    );
    stream_mux #(.WIDTH(8), .N(4), .MODE(1)) u_fx (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(fx_in_ready),
        .sel(sel), .out_data(fx_out_data), .out_valid(fx_out_valid), .out_ready(out_ready),
        .out_src(fx_out_src)
    );
    stream_mux #(.WIDTH(8), .N(4), .MODE(2)) u_sl (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(sl_in_ready),
        .sel(sel), .out_data(sl_out_data), .out_valid(sl_out_valid), .out_ready(out_ready),
        .out_src(sl_out_src)
    );
    stream_mux #(.WIDTH(8), .N(3), .MODE(0)) u_rr3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
        .out_src(out_src3)
    );

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (rr_out_valid !== 1'b0) $display("FAIL reset_rr_valid: got %0b want 0", rr_out_valid); else passed++;
            total++; if (rr_out_data !== 8'h00) $display("FAIL reset_rr_data: got %h want 00", rr_out_data); else passed++;
            total++; if (rr_in_ready !== 4'b0000) $display("FAIL reset_rr_ready: got %b want 0000", rr_in_ready); else passed++;
            total++; if ({fx_in_ready, sl_in_ready} !== 8'h00) $display("FAIL reset_fx_sl_ready: got %b want 00000000", {fx_in_ready, sl_in_ready}); else passed++;
        end
        rst = 1'b0;
        #1;
        total++; if (rr_in_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", rr_in_ready); else passed++;
    endtask

    task automatic test_rr_fairness();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            total++; if (rr_out_valid !== 1'b1) $display("FAIL rr_valid[%0d]: got %0b want 1", k, rr_out_valid); else passed++;
            total++; if (rr_out_src !== 2'(k % 4)) $display("FAIL rr_src[%0d]: got %0d want %0d", k, rr_out_src, k % 4); else passed++;
            total++; if (rr_out_data !== 8'hA0 + 8'(k % 4)) $display("FAIL rr_data[%0d]: got %h want %h", k, rr_out_data, 8'hA0 + 8'(k % 4)); else passed++;
        end
    endtask

    task automatic test_fixed_priority();
        in_valid = 4'b1010;
        #1;
        total++; if (fx_in_ready !== 4'b0010) $display("FAIL fx_ready_1010: got %b want 0010", fx_in_ready); else passed++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++; if (fx_out_src !== 2'd1) $display("FAIL fx_src[%0d]: got %0d want 1", k, fx_out_src); else passed++;
            total++; if (fx_out_data !== 8'hA1) $display("FAIL fx_data[%0d]: got %h want a1", k, fx_out_data); else passed++;
        end
        in_valid = 4'b1000;
        #1;
        total++; if (fx_in_ready !== 4'b1000) $display("FAIL fx_ready_1000: got %b want 1000", fx_in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (fx_out_src !== 2'd3) $display("FAIL fx_src_ch3: got %0d want 3", fx_out_src); else passed++;
        total++; if (fx_out_data !== 8'hA3) $display("FAIL fx_data_ch3: got %h want a3", fx_out_data); else passed++;
    endtask

    task automatic test_external_select();
        sel = 2'd2;
        in_valid = 4'b0100;
        #1;
        total++; if (sl_in_ready !== 4'b0100) $display("FAIL sl_ready_0100: got %b want 0100", sl_in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (sl_out_valid !== 1'b1) $display("FAIL sl_valid: got %0b want 1", sl_out_valid); else passed++;
        total++; if (sl_out_src !== 2'd2) $display("FAIL sl_src: got %0d want 2", sl_out_src); else passed++;
        total++; if (sl_out_data !== 8'hA2) $display("FAIL sl_data: got %h want a2", sl_out_data); else passed++;
        in_valid = 4'b1011;
        #1;
        total++; if (sl_in_ready !== 4'b0000) $display("FAIL sl_ready_1011: got %b want 0000", sl_in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (sl_out_valid !== 1'b0) $display("FAIL sl_no_xfer_valid: got %0b want 0", sl_out_valid); else passed++;
        total++; if (sl_out_src !== 2'd2) $display("FAIL sl_src_hold: got %0d want 2", sl_out_src); else passed++;
    endtask

    task automatic test_backpressure();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (rr_out_src !== 2'd0) $display("FAIL bp_first_src: got %0d want 0", rr_out_src); else passed++;
        out_ready = 1'b0;
        #1;
        total++; if (rr_in_ready !== 4'b0000) $display("FAIL bp_ready_stall: got %b want 0000", rr_in_ready); else passed++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (rr_out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %0b want 1", c, rr_out_valid); else passed++;
            total++; if (rr_out_src !== 2'd0) $display("FAIL bp_src[%0d]: got %0d want 0", c, rr_out_src); else passed++;
            total++; if (rr_out_data !== 8'hA0) $display("FAIL bp_data[%0d]: got %h want a0", c, rr_out_data); else passed++;
            total++; if (rr_in_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", c, rr_in_ready); else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (rr_in_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b want 0010", rr_in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (rr_out_valid !== 1'b1) $display("FAIL bp_next_valid: got %0b want 1", rr_out_valid); else passed++;
        total++; if (rr_out_src !== 2'd1) $display("FAIL bp_next_src: got %0d want 1", rr_out_src); else passed++;
        total++; if (rr_out_data !== 8'hA1) $display("FAIL bp_next_data: got %h want a1", rr_out_data); else passed++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (rr_in_ready !== 4'b0000) $display("FAIL mid_ready_in_rst: got %b want 0000", rr_in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (rr_out_valid !== 1'b0) $display("FAIL mid_valid: got %0b want 0", rr_out_valid); else passed++;
        total++; if (rr_out_data !== 8'h00) $display("FAIL mid_data: got %h want 00", rr_out_data); else passed++;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        total++; if (rr_in_ready !== 4'b0001) $display("FAIL mid_restart_ready: got %b want 0001", rr_in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (rr_out_src !== 2'd0) $display("FAIL mid_restart_src: got %0d want 0", rr_out_src); else passed++;
        total++; if (rr_out_data !== 8'hA0) $display("FAIL mid_restart_data: got %h want a0", rr_out_data); else passed++;
    endtask

    task automatic test_nonpow2_wrap();
        in_valid3 = 3'b111;
        #1;
        total++; if (in_ready3 !== 3'b001) $display("FAIL n3_first_ready: got %b want 001", in_ready3); else passed++;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            total++; if (out_src3 !== 2'(k % 3)) $display("FAIL n3_src[%0d]: got %0d want %0d", k, out_src3, k % 3); else passed++;
            total++; if (out_data3 !== 8'hC0 + 8'(k % 3)) $display("FAIL n3_data[%0d]: got %h want %h", k, out_data3, 8'hC0 + 8'(k % 3)); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_external_select();
        test_backpressure();
        test_reset_midstream();
        test_nonpow2_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
